// File: rtl/qlf_bram_pkg.sv
// Shared definitions for the TDP36K preload (PL_*) port initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, PL_ADDR layout {sel, word address}, write-enable
// pattern, data/length widths and the session length clamp helper.
package qlf_bram_pkg;

  localparam int ADDR_W    = 14;               // word-address field, PL_ADDR[ADDR_W-1:0]
  localparam int SEL_W     = 10;               // block-select field, PL_ADDR[23:ADDR_W]
  localparam int PL_ADDR_W = ADDR_W + SEL_W;   // 24
  localparam int PL_DATA_W = 36;
  localparam int LEN_W     = 11;
  localparam int DEPTH     = 1024;             // max words per session

  localparam logic [1:0] WEN_ALL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_RD_SETUP,
    ST_RD_PULSE,
    ST_RD_CMP,
    ST_FINISH
  } pl_state_t;

  // Requested lengths beyond one BRAM are truncated to one BRAM.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
  endfunction

endpackage

// File: rtl/bram_preload_ctrl_if.sv
// Bundle of the init-word stream and the PL_* preload pins of one BRAM.
// Latency: n/a (wiring only).
// Backpressure: s_valid_i/s_ready_o handshake on the stream side; the PL side has none.
// Ports: master = preload controller (consumes stream, drives PL_*);
//        slave  = surroundings (config loader feeding the stream, BRAM answering PL_DATA_i).
interface bram_preload_ctrl_if;
  import qlf_bram_pkg::*;

  logic                 s_valid_i;
  logic                 s_ready_o;
  logic [PL_DATA_W-1:0] s_data_i;

  logic                 PL_INIT_o;
  logic                 PL_ENA_o;
  logic [1:0]           PL_WEN_o;
  logic                 PL_REN_o;
  logic                 PL_CLK_o;
  logic [PL_ADDR_W-1:0] PL_ADDR_o;
  logic [PL_DATA_W-1:0] PL_DATA_o;
  logic [PL_DATA_W-1:0] PL_DATA_i;

  modport master (
    input  s_valid_i, s_data_i, PL_DATA_i,
    output s_ready_o, PL_INIT_o, PL_ENA_o, PL_WEN_o, PL_REN_o, PL_CLK_o, PL_ADDR_o, PL_DATA_o
  );

  modport slave (
    output s_valid_i, s_data_i, PL_DATA_i,
    input  s_ready_o, PL_INIT_o, PL_ENA_o, PL_WEN_o, PL_REN_o, PL_CLK_o, PL_ADDR_o, PL_DATA_o
  );

endinterface

// File: rtl/bram_preload_ctrl.sv
// Writes a stream of 36-bit init words into one BRAM through its PL_* preload port,
// optionally reading each word back. Latency: 3 cycles/word (6 with verify) plus stalls.
// Backpressure: s_ready_o only in FETCH; a stalled stream parks the FSM with PL_CLK low.
// Ports: CLK_i/RESET_i (sync, active-high); start_i/verify_i/base_i/len_i/sel_i session
// parameters sampled on start; abort_i; bus (stream + PL_* pins); busy_o, done_o pulse,
// err_o (sticky verify mismatch) and err_addr_o (first mismatching word address).
module bram_preload_ctrl
  import qlf_bram_pkg::*;
(
  input  logic              CLK_i,
  input  logic              RESET_i,
  input  logic              start_i,
  input  logic              verify_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              abort_i,
  bram_preload_ctrl_if.master bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  pl_state_t state_q, state_d;

  logic                 verify_q;
  logic                 abort_q;     // remembers an abort seen mid-word until a decision point
  logic [ADDR_W-1:0]    addr_q;
  logic [SEL_W-1:0]     sel_q;
  logic [LEN_W-1:0]     remain_q;
  logic [PL_DATA_W-1:0] data_q;
  logic                 err_q;
  logic [ADDR_W-1:0]    err_addr_q;

  // PL strobes are registered copies of the next-state decode, so pins never glitch.
  logic       init_q, ena_q, ren_q, plclk_q, done_q;
  logic [1:0] wen_q;
  logic       init_d, ena_d, ren_d, plclk_d, done_d;
  logic [1:0] wen_d;

  logic stop, last, mismatch, s_ready, hs, word_done;

  assign stop      = abort_i | abort_q;
  assign last      = (remain_q == '0);
  assign mismatch  = (bus.PL_DATA_i != data_q);
  // Refusing the word while aborting keeps an accepted word from being silently dropped.
  assign s_ready   = (state_q == ST_FETCH) & ~stop;
  assign hs        = bus.s_valid_i & s_ready;
  assign word_done = ((state_q == ST_WR_PULSE) & ~verify_q) |
                     ((state_q == ST_RD_CMP) & ~mismatch);

  always_ff @(posedge CLK_i) begin
    if (RESET_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    init_d  = 1'b0;
    ena_d   = 1'b0;
    wen_d   = 2'b00;
    ren_d   = 1'b0;
    plclk_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE:     if (start_i) state_d = (len_i == '0) ? ST_FINISH : ST_FETCH;
      ST_FETCH:    if (stop) state_d = ST_FINISH;
                   else if (hs) state_d = ST_WR_SETUP;
      ST_WR_SETUP: state_d = ST_WR_PULSE;
      ST_WR_PULSE: state_d = verify_q ? ST_RD_SETUP : ((last | stop) ? ST_FINISH : ST_FETCH);
      ST_RD_SETUP: state_d = ST_RD_PULSE;
      ST_RD_PULSE: state_d = ST_RD_CMP;
      ST_RD_CMP:   state_d = (mismatch | last | stop) ? ST_FINISH : ST_FETCH;
      ST_FINISH:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_FETCH:    init_d = 1'b1;
      ST_WR_SETUP: begin init_d = 1'b1; ena_d = 1'b1; wen_d = WEN_ALL; end
      ST_WR_PULSE: begin init_d = 1'b1; ena_d = 1'b1; wen_d = WEN_ALL; plclk_d = 1'b1; end
      ST_RD_SETUP: begin init_d = 1'b1; ena_d = 1'b1; ren_d = 1'b1; end
      ST_RD_PULSE: begin init_d = 1'b1; ena_d = 1'b1; ren_d = 1'b1; plclk_d = 1'b1; end
      ST_RD_CMP:   begin init_d = 1'b1; ena_d = 1'b1; ren_d = 1'b1; end
      ST_FINISH:   done_d = 1'b1;
      default:     ;
    endcase
  end

  always_ff @(posedge CLK_i) begin
    if (RESET_i) begin
      init_q     <= 1'b0;
      ena_q      <= 1'b0;
      wen_q      <= 2'b00;
      ren_q      <= 1'b0;
      plclk_q    <= 1'b0;
      done_q     <= 1'b0;
      verify_q   <= 1'b0;
      abort_q    <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      remain_q   <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      init_q  <= init_d;
      ena_q   <= ena_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      plclk_q <= plclk_d;
      done_q  <= done_d;

      if (state_q == ST_IDLE) abort_q <= 1'b0;
      else if (abort_i)       abort_q <= 1'b1;

      if ((state_q == ST_IDLE) && start_i) begin
        verify_q   <= verify_i;
        addr_q     <= base_i;
        sel_q      <= sel_i;
        remain_q   <= clamp_len(len_i);
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end

      if (hs) begin
        data_q   <= bus.s_data_i;
        remain_q <= remain_q - LEN_W'(1);
      end

      // Advances only after the pulse has dropped, so ADDR is stable under PL_CLK;
      // natural overflow wraps inside the word field and never touches sel.
      if (word_done) addr_q <= addr_q + ADDR_W'(1);

      if ((state_q == ST_RD_CMP) && mismatch) begin
        err_q      <= 1'b1;
        err_addr_q <= addr_q;
      end
    end
  end

  assign bus.s_ready_o = s_ready;
  assign bus.PL_INIT_o = init_q;
  assign bus.PL_ENA_o  = ena_q;
  assign bus.PL_WEN_o  = wen_q;
  assign bus.PL_REN_o  = ren_q;
  assign bus.PL_CLK_o  = plclk_q;
  assign bus.PL_ADDR_o = {sel_q, addr_q};
  assign bus.PL_DATA_o = data_q;

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_bram_preload_ctrl.sv
// Bench for bram_preload_ctrl: stream source, echoing BRAM model with optional corruption,
// and a PL pulse monitor feeding an event scoreboard.
// Expected PL events are queued as words are queued; observed events are compared after done_o.
module tb_bram_preload_ctrl;
  import qlf_bram_pkg::*;

  logic        CLK_i = 1'b0;
  logic        RESET_i;
  logic        start_i, verify_i, abort_i;
  logic [13:0] base_i;
  logic [10:0] len_i;
  logic [9:0]  sel_i;
  logic        busy_o, done_o, err_o;
  logic [13:0] err_addr_o;

  bram_preload_ctrl_if bus();

  bram_preload_ctrl dut (
    .CLK_i      (CLK_i),
    .RESET_i    (RESET_i),
    .start_i    (start_i),
    .verify_i   (verify_i),
    .base_i     (base_i),
    .len_i      (len_i),
    .sel_i      (sel_i),
    .abort_i    (abort_i),
    .bus        (bus),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_addr_o (err_addr_o)
  );

  always #5 CLK_i = ~CLK_i;

  int cyc = 0;
  always @(posedge CLK_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
    logic [35:0] data;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  logic [35:0] src_q[$];
  int          gap_cfg = 0;

  // BRAM responder model
  logic [35:0] mem [0:16383];
  bit          corrupt_en = 1'b0;
  logic [13:0] corrupt_addr = '0;
  logic [35:0] flip;
  always @(posedge bus.PL_CLK_o) begin
    flip = (corrupt_en && bus.PL_ADDR_o[13:0] == corrupt_addr) ? 36'h20 : 36'h0;
    if (bus.PL_WEN_o == 2'b11) mem[bus.PL_ADDR_o[13:0]] <= bus.PL_DATA_o;
    if (bus.PL_REN_o) bus.PL_DATA_i <= mem[bus.PL_ADDR_o[13:0]] ^ flip;
  end

  // PL monitor: one event per strobe
  always @(negedge CLK_i) begin
    if (bus.PL_CLK_o === 1'b1) begin
      if (bus.PL_WEN_o === 2'b11) obs_q.push_back({1'b1, bus.PL_ADDR_o, bus.PL_DATA_o});
      else if (bus.PL_REN_o === 1'b1) obs_q.push_back({1'b0, bus.PL_ADDR_o, 36'h0});
    end
  end

  // Stream source: gap_cfg = number of ready-but-not-valid cycles inserted between words
  bit hs_pending = 1'b0;
  int gap_cnt = 0;
  initial begin
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;
    forever begin
      @(negedge CLK_i);
      if (hs_pending && src_q.size() > 0) begin
        void'(src_q.pop_front());
        gap_cnt = (src_q.size() > 0) ? gap_cfg : 0;
      end
      #1;
      if (gap_cnt > 0) begin
        bus.s_valid_i = 1'b0;
        if (bus.s_ready_o === 1'b1) gap_cnt--;
      end else if (src_q.size() > 0) begin
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = src_q[0];
      end else begin
        bus.s_valid_i = 1'b0;
      end
      hs_pending = bus.s_valid_i & (bus.s_ready_o === 1'b1) & ~RESET_i;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic queue_word(input logic [9:0] sel, input logic [13:0] addr, input logic [35:0] data,
                            input bit expect_wr, input bit expect_rd);
    src_q.push_back(data);
    if (expect_wr) exp_q.push_back({1'b1, sel, addr, data});
    if (expect_rd) exp_q.push_back({1'b0, sel, addr, 36'h0});
  endtask

  task automatic start_session(input logic vfy, input logic [13:0] base, input logic [10:0] len,
                               input logic [9:0] sel, output int scyc);
    @(negedge CLK_i);
    verify_i = vfy; base_i = base; len_i = len; sel_i = sel; start_i = 1'b1;
    scyc = cyc;
    @(negedge CLK_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc, output bit ok);
    int n = 0;
    ok = 1'b0; dcyc = 0;
    while (n < budget) begin
      if (done_o === 1'b1) begin ok = 1'b1; dcyc = cyc; break; end
      @(negedge CLK_i);
      n++;
    end
  endtask

  task automatic test_reset();
    RESET_i = 1'b1;
    repeat (3) @(negedge CLK_i);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy_o); end
    n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done_o); end
    n_checks++; if (err_o !== 1'b0 || err_addr_o !== 14'h0) begin
      n_fail++; $display("FAIL rst_err got %b/%h want 0/0000", err_o, err_addr_o); end
    n_checks++; if ({bus.PL_INIT_o, bus.PL_ENA_o, bus.PL_WEN_o, bus.PL_REN_o, bus.PL_CLK_o} !== 6'b0) begin
      n_fail++; $display("FAIL rst_pl_ctl got %b want 000000",
                         {bus.PL_INIT_o, bus.PL_ENA_o, bus.PL_WEN_o, bus.PL_REN_o, bus.PL_CLK_o}); end
    n_checks++; if (bus.PL_ADDR_o !== 24'h0 || bus.PL_DATA_o !== 36'h0) begin
      n_fail++; $display("FAIL rst_pl_bus got %h/%h want 0/0", bus.PL_ADDR_o, bus.PL_DATA_o); end
    n_checks++; if (bus.s_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b want 0", bus.s_ready_o); end
    RESET_i = 1'b0;
  endtask

  task automatic test_write();
    int scyc, dcyc; bit ok; ev_t e, o;
    logic [35:0] w [3] = '{36'hA_1234_5678, 36'hB_9ABC_DEF0, 36'hC_0F0F_F0F0};
    for (int i = 0; i < 3; i++) queue_word(10'h2A5, 14'h010 + 14'(i), w[i], 1'b1, 1'b0);
    start_session(1'b0, 14'h010, 11'd3, 10'h2A5, scyc);
    n_checks++; if ({busy_o, bus.PL_INIT_o, bus.s_ready_o, bus.PL_CLK_o} !== 4'b1110) begin
      n_fail++; $display("FAIL wr_fetch_state got %b want 1110", {busy_o, bus.PL_INIT_o, bus.s_ready_o, bus.PL_CLK_o}); end
    wait_done(60, dcyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wr_done_timeout got none want done_o"); end
    n_checks++; if (dcyc - scyc !== 10) begin n_fail++; $display("FAIL wr_latency got %0d want 10", dcyc - scyc); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL wr_err got %b want 0", err_o); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wr_events got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL wr_event got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_verify();
    int scyc, dcyc; bit ok; ev_t e, o;
    logic [35:0] w [3] = '{36'h1_1111_1111, 36'h2_2222_2222, 36'h3_3333_3333};
    for (int i = 0; i < 3; i++) queue_word(10'h2A5, 14'h010 + 14'(i), w[i], 1'b1, 1'b1);
    start_session(1'b1, 14'h010, 11'd3, 10'h2A5, scyc);
    wait_done(80, dcyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL vf_done_timeout got none want done_o"); end
    n_checks++; if (dcyc - scyc !== 19) begin n_fail++; $display("FAIL vf_latency got %0d want 19", dcyc - scyc); end
    n_checks++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL vf_err got %b want 0", err_o); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL vf_events got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL vf_event got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_verify_err();
    int scyc, dcyc; bit ok; ev_t e, o;
    logic [35:0] w [3] = '{36'h4_0000_0001, 36'h5_0000_0002, 36'h6_0000_0003};
    corrupt_en = 1'b1; corrupt_addr = 14'h021;
    queue_word(10'h001, 14'h020, w[0], 1'b1, 1'b1);
    queue_word(10'h001, 14'h021, w[1], 1'b1, 1'b1);
    queue_word(10'h001, 14'h022, w[2], 1'b0, 1'b0);
    start_session(1'b1, 14'h020, 11'd3, 10'h001, scyc);
    wait_done(80, dcyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ve_done_timeout got none want done_o"); end
    n_checks++; if (dcyc - scyc !== 13) begin n_fail++; $display("FAIL ve_latency got %0d want 13", dcyc - scyc); end
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ve_err got %b want 1", err_o); end
    n_checks++; if (err_addr_o !== 14'h021) begin n_fail++; $display("FAIL ve_err_addr got %h want 0021", err_addr_o); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ve_events got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL ve_event got %h want %h", o, e); end
    end
    repeat (2) @(negedge CLK_i);
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL ve_err_sticky got %b want 1", err_o); end
    @(posedge CLK_i);
    src_q.delete(); exp_q.delete(); obs_q.delete();
    corrupt_en = 1'b0;
  endtask

  task automatic test_wrap();
    int scyc, dcyc; bit ok; ev_t e, o;
    queue_word(10'h155, 14'h3FFF, 36'h7_DEAD_BEEF, 1'b1, 1'b0);
    queue_word(10'h155, 14'h0000, 36'h8_CAFE_F00D, 1'b1, 1'b0);
    start_session(1'b0, 14'h3FFF, 11'd2, 10'h155, scyc);
    n_checks++; if (err_o !== 1'b0 || err_addr_o !== 14'h0) begin
      n_fail++; $display("FAIL wp_err_cleared got %b/%h want 0/0000", err_o, err_addr_o); end
    wait_done(60, dcyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wp_done_timeout got none want done_o"); end
    n_checks++; if (dcyc - scyc !== 7) begin n_fail++; $display("FAIL wp_latency got %0d want 7", dcyc - scyc); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wp_events got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL wp_event got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall();
    int scyc, dcyc, n; bit ok; ev_t e, o;
    gap_cfg = 4;
    queue_word(10'h3C3, 14'h100, 36'h9_5555_AAAA, 1'b1, 1'b0);
    queue_word(10'h3C3, 14'h101, 36'hA_AAAA_5555, 1'b1, 1'b0);
    start_session(1'b0, 14'h100, 11'd2, 10'h3C3, scyc);
    n = 0;
    while (bus.PL_CLK_o !== 1'b1 && n < 20) begin @(negedge CLK_i); n++; end
    n_checks++; if (bus.PL_CLK_o !== 1'b1) begin n_fail++; $display("FAIL st_first_pulse got none want pulse"); end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK_i);
      n_checks++;
      if ({bus.PL_CLK_o, bus.PL_ADDR_o, bus.PL_DATA_o} !== {1'b0, 10'h3C3, 14'h101, 36'h9_5555_AAAA}) begin
        n_fail++; $display("FAIL st_hold[%0d] got clk=%b addr=%h data=%h want clk=0 addr=f0c101 data=955555aaaa",
                           k, bus.PL_CLK_o, bus.PL_ADDR_o, bus.PL_DATA_o); end
    end
    wait_done(60, dcyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL st_done_timeout got none want done_o"); end
    n_checks++; if (dcyc - scyc !== 11) begin n_fail++; $display("FAIL st_latency got %0d want 11", dcyc - scyc); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL st_events got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL st_event got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    gap_cfg = 0;
    // empty session
    start_session(1'b0, 14'h200, 11'd0, 10'h3C3, scyc);
    wait_done(10, dcyc, ok);
    n_checks++; if (!ok || dcyc - scyc !== 1) begin
      n_fail++; $display("FAIL len0_done got ok=%b lat=%0d want ok=1 lat=1", ok, dcyc - scyc); end
    n_checks++; if ({bus.PL_INIT_o, bus.PL_ENA_o, bus.PL_CLK_o} !== 3'b000) begin
      n_fail++; $display("FAIL len0_pl got %b want 000", {bus.PL_INIT_o, bus.PL_ENA_o, bus.PL_CLK_o}); end
    @(negedge CLK_i);
    n_checks++; if (obs_q.size() != 0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL len0_idle got events=%0d busy=%b want 0/0", obs_q.size(), busy_o); end
  endtask

  task automatic test_reset_abort();
    int scyc, dcyc, n, pulses; bit ok, seen_done; ev_t e, o;
    queue_word(10'h0AA, 14'h040, 36'h1_0000_0040, 1'b1, 1'b0);
    queue_word(10'h0AA, 14'h041, 36'h1_0000_0041, 1'b1, 1'b0);
    queue_word(10'h0AA, 14'h042, 36'h1_0000_0042, 1'b0, 1'b0);
    start_session(1'b0, 14'h040, 11'd3, 10'h0AA, scyc);
    n = 0; pulses = 0;
    while (pulses < 2 && n < 40) begin
      @(negedge CLK_i); n++;
      if (bus.PL_CLK_o === 1'b1) pulses++;
    end
    RESET_i = 1'b1;
    @(negedge CLK_i);
    n_checks++; if ({busy_o, done_o, bus.PL_INIT_o, bus.PL_ENA_o, bus.PL_WEN_o, bus.PL_REN_o, bus.PL_CLK_o} !== 8'b0) begin
      n_fail++; $display("FAIL rm_outputs got %b want 00000000",
                         {busy_o, done_o, bus.PL_INIT_o, bus.PL_ENA_o, bus.PL_WEN_o, bus.PL_REN_o, bus.PL_CLK_o}); end
    n_checks++; if (bus.PL_ADDR_o !== 24'h0 || bus.PL_DATA_o !== 36'h0) begin
      n_fail++; $display("FAIL rm_bus got %h/%h want 0/0", bus.PL_ADDR_o, bus.PL_DATA_o); end
    RESET_i = 1'b0;
    seen_done = 1'b0;
    repeat (4) begin @(negedge CLK_i); if (done_o === 1'b1) seen_done = 1'b1; end
    n_checks++; if (seen_done) begin n_fail++; $display("FAIL rm_no_done got done_o pulse want none"); end
    @(posedge CLK_i);
    src_q.delete();
    n_checks++; if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rm_events got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL rm_event got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    // abort while waiting for the first word
    start_session(1'b0, 14'h050, 11'd3, 10'h0AA, scyc);
    abort_i = 1'b1;
    @(negedge CLK_i);
    abort_i = 1'b0;
    wait_done(10, dcyc, ok);
    n_checks++; if (!ok || dcyc - scyc !== 2) begin
      n_fail++; $display("FAIL ab_done got ok=%b lat=%0d want ok=1 lat=2", ok, dcyc - scyc); end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL ab_events got %0d want 0", obs_q.size()); end
    @(negedge CLK_i);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ab_idle got busy=%b want 0", busy_o); end
  endtask

  initial begin
    RESET_i = 1'b1; start_i = 1'b0; verify_i = 1'b0; abort_i = 1'b0;
    base_i = '0; len_i = '0; sel_i = '0;
    test_reset();
    test_write();
    test_verify();
    test_verify_err();
    test_wrap();
    test_stall();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
